// File: rtl/z80ctc_daisy.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | z80ctc_daisy : CHANNELS-wide Z80 CTC with triggers, IM2 daisy chain, RETI |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module z80ctc_daisy #(
  parameter int CHANNELS = 4,
  parameter int CS_W     = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                clock_ena,
  input  logic [7:0]          din,
  output logic [7:0]          dout,
  input  logic [7:0]          cpu_din,
  input  logic                ce_n,
  input  logic [CS_W-1:0]     cs,
  input  logic                m1_n,
  input  logic                iorq_n,
  input  logic                rd_n,
  input  logic [CHANNELS-1:0] trg,
  output logic [CHANNELS-1:0] zc_to,
  output logic                int_n,
  input  logic                iei,
  output logic                ieo
);

  localparam int BW = 7 - CS_W;
  // control word bits 7..3 are kept; indices into the stored 5-bit field
  localparam int C_IE   = 4;
  localparam int C_CNT  = 3;
  localparam int C_P256 = 2;
  localparam int C_RISE = 1;
  localparam int C_TRG  = 0;

  typedef enum logic [0:0] {RETI_IDLE = 1'b0, RETI_SEEN_ED = 1'b1} reti_state_t;

  logic [7:0]          tc_q    [CHANNELS];
  logic [7:0]          tc_d    [CHANNELS];
  logic [8:0]          cnt_q   [CHANNELS];
  logic [8:0]          cnt_d   [CHANNELS];
  logic [7:0]          presc_q [CHANNELS];
  logic [7:0]          presc_d [CHANNELS];
  logic [4:0]          ctrl_q  [CHANNELS];
  logic [4:0]          ctrl_d  [CHANNELS];
  logic [2:0]          sync_q  [CHANNELS];
  logic [2:0]          sync_d  [CHANNELS];
  logic [CHANNELS-1:0] run_q, run_d, arm_q, arm_d, await_q, await_d;
  logic [CHANNELS-1:0] pend_q, pend_d, ins_q, ins_d, zc_q, zc_d;
  logic [BW-1:0]       base_q, base_d;
  logic [7:0]          dout_q, dout_d;
  logic                done_q, done_d;
  logic [CHANNELS-1:0] req;
  reti_state_t         reti_state_q;
  logic                reti_q;
  logic                m1_prev_q;

  function automatic logic [8:0] f_reload(input logic [7:0] v);
    return (v == 8'd0) ? 9'd256 : {1'b0, v};
  endfunction

  // Lower index wins; an in-service channel blocks itself and everything below it.
  always_comb begin
    logic blk;
    blk = 1'b0;
    req = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      blk    = blk | ins_q[i];
      req[i] = iei & pend_q[i] & ~blk;
    end
  end

  assign int_n = ~|req;
  assign ieo   = iei & ~|ins_q & ~|pend_q;
  assign dout  = dout_q;
  assign zc_to = zc_q;

  always_comb begin
    logic acc_wr, acc_rd, hit_ack, hit_reti, act_edge, dec;
    tc_d    = tc_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    ctrl_d  = ctrl_q;
    sync_d  = sync_q;
    run_d   = run_q;
    arm_d   = arm_q;
    await_d = await_q;
    pend_d  = pend_q;
    ins_d   = ins_q;
    zc_d    = '0;
    base_d  = base_q;
    dout_d  = dout_q;
    done_d  = done_q;
    acc_wr  = 1'b0;
    acc_rd  = 1'b0;
    hit_ack = 1'b0;
    hit_reti = 1'b0;
    act_edge = 1'b0;
    dec     = 1'b0;

    if (iorq_n) begin
      done_d = 1'b0;
      dout_d = 8'hFF;
    end else if (!done_q) begin
      done_d = 1'b1;
      if (!m1_n) begin
        dout_d = 8'hFF;
        for (int i = 0; i < CHANNELS; i++) begin
          if (req[i] && !hit_ack) begin
            hit_ack   = 1'b1;
            pend_d[i] = 1'b0;
            ins_d[i]  = 1'b1;
            dout_d    = {base_q, CS_W'(i), 1'b0};
          end
        end
      end else if (!ce_n) begin
        acc_wr = rd_n;
        acc_rd = ~rd_n;
        if (acc_rd) dout_d = 8'hFF;
      end else begin
        done_d = 1'b0;
      end
    end

    for (int i = 0; i < CHANNELS; i++) begin
      if (reti_q && ins_q[i] && !hit_reti) begin
        hit_reti = 1'b1;
        ins_d[i] = 1'b0;
      end
    end

    for (int i = 0; i < CHANNELS; i++) begin
      sync_d[i] = {sync_q[i][1:0], trg[i]};
      act_edge  = ctrl_q[i][C_RISE] ? (sync_q[i][1] & ~sync_q[i][2])
                                    : (~sync_q[i][1] & sync_q[i][2]);
      dec = 1'b0;
      if (run_q[i]) begin
        if (ctrl_q[i][C_CNT]) begin
          dec = act_edge;
        end else if (presc_q[i] == (ctrl_q[i][C_P256] ? 8'hFF : 8'h0F)) begin
          presc_d[i] = 8'd0;
          dec        = 1'b1;
        end else begin
          presc_d[i] = presc_q[i] + 8'd1;
        end
      end
      if (arm_q[i] && act_edge) begin
        arm_d[i]   = 1'b0;
        run_d[i]   = 1'b1;
        presc_d[i] = 8'd0;
      end
      // Zero is reached on the decrement from 1; the reload value 256 encodes TC=0.
      if (dec) begin
        if (cnt_q[i] == 9'd1) begin
          cnt_d[i] = f_reload(tc_q[i]);
          zc_d[i]  = 1'b1;
          if (ctrl_q[i][C_IE]) pend_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - 9'd1;
        end
      end

      if (acc_wr && int'(cs) == i) begin
        if (await_q[i]) begin
          tc_d[i]    = din;
          await_d[i] = 1'b0;
          if (!run_q[i]) begin
            cnt_d[i]   = f_reload(din);
            presc_d[i] = 8'd0;
            if (!ctrl_q[i][C_CNT] && ctrl_q[i][C_TRG]) begin
              arm_d[i] = 1'b1;
              run_d[i] = 1'b0;
            end else begin
              run_d[i] = 1'b1;
            end
          end
        end else if (din[0]) begin
          ctrl_d[i]  = din[7:3];
          await_d[i] = din[2];
          if (!din[7]) pend_d[i] = 1'b0;
          if (din[1]) begin
            run_d[i]  = 1'b0;
            arm_d[i]  = 1'b0;
            pend_d[i] = 1'b0;
            zc_d[i]   = 1'b0;
            cnt_d[i]  = cnt_q[i];
          end
        end else if (i == 0) begin
          base_d = din[7:CS_W+1];
        end
      end

      if (acc_rd && int'(cs) == i) dout_d = cnt_q[i][7:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        tc_q[i]    <= '0;
        cnt_q[i]   <= '0;
        presc_q[i] <= '0;
        ctrl_q[i]  <= '0;
        sync_q[i]  <= '0;
      end
      run_q   <= '0;
      arm_q   <= '0;
      await_q <= '0;
      pend_q  <= '0;
      ins_q   <= '0;
      zc_q    <= '0;
      base_q  <= '0;
      dout_q  <= 8'hFF;
      done_q  <= 1'b0;
    end else if (clock_ena) begin
      tc_q    <= tc_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      ctrl_q  <= ctrl_d;
      sync_q  <= sync_d;
      run_q   <= run_d;
      arm_q   <= arm_d;
      await_q <= await_d;
      pend_q  <= pend_d;
      ins_q   <= ins_d;
      zc_q    <= zc_d;
      base_q  <= base_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

  // Opcode fetch ends when M1 rises outside an I/O cycle; ED 4D marks RETI.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      reti_state_q <= RETI_IDLE;
      reti_q       <= 1'b0;
      m1_prev_q    <= 1'b1;
    end else if (clock_ena) begin
      m1_prev_q <= m1_n;
      reti_q    <= 1'b0;
      if (!m1_prev_q && m1_n && iorq_n) begin
        case (reti_state_q)
          RETI_IDLE: begin
            if (cpu_din == 8'hED) reti_state_q <= RETI_SEEN_ED;
          end
          RETI_SEEN_ED: begin
            if (cpu_din == 8'h4D) begin
              reti_q       <= 1'b1;
              reti_state_q <= RETI_IDLE;
            end else if (cpu_din != 8'hED) begin
              reti_state_q <= RETI_IDLE;
            end
          end
          default: reti_state_q <= RETI_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_z80ctc_daisy.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_z80ctc_daisy : scoreboard bench for z80ctc_daisy                       |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_z80ctc_daisy;

  localparam int CHANNELS = 4;
  localparam int CS_W     = 2;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic                clock_ena = 1'b1;
  logic [7:0]          din = 8'h00;
  logic [7:0]          dout;
  logic [7:0]          cpu_din = 8'h00;
  logic                ce_n = 1'b1;
  logic [CS_W-1:0]     cs = '0;
  logic                m1_n = 1'b1;
  logic                iorq_n = 1'b1;
  logic                rd_n = 1'b1;
  logic [CHANNELS-1:0] trg = '0;
  logic [CHANNELS-1:0] zc_to;
  logic                int_n;
  logic                iei = 1'b1;
  logic                ieo;

  int n_vec = 0;
  int n_err = 0;
  int ena_cnt = 0;
  int wr_cyc = 0;
  int exp_q[$];

  z80ctc_daisy #(.CHANNELS(CHANNELS), .CS_W(CS_W)) u_dut (
    .clock(clock), .reset_n(reset_n), .clock_ena(clock_ena),
    .din(din), .dout(dout), .cpu_din(cpu_din), .ce_n(ce_n), .cs(cs),
    .m1_n(m1_n), .iorq_n(iorq_n), .rd_n(rd_n), .trg(trg), .zc_to(zc_to),
    .int_n(int_n), .iei(iei), .ieo(ieo)
  );

  always #5 clock = ~clock;
  always @(posedge clock) if (clock_ena) ena_cnt <= ena_cnt + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic io_write(input int ch, input logic [7:0] d);
    cs = CS_W'(ch); din = d; rd_n = 1'b1; ce_n = 1'b0; iorq_n = 1'b0;
    tick(1);
    wr_cyc = ena_cnt;
    ce_n = 1'b1; iorq_n = 1'b1;
    tick(1);
  endtask

  task automatic io_read(input string tag, input int ch, input logic [7:0] exp);
    exp_q.push_back(int'(exp));
    cs = CS_W'(ch); rd_n = 1'b0; ce_n = 1'b0; iorq_n = 1'b0;
    tick(1);
    chk(tag, dout, exp_q.pop_front());
    ce_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1;
    tick(1);
  endtask

  task automatic intack(input string tag, input logic [7:0] exp);
    exp_q.push_back(int'(exp));
    exp_q.push_back(int'(exp));
    m1_n = 1'b0; iorq_n = 1'b0;
    tick(1);
    chk(tag, dout, exp_q.pop_front());
    tick(1);
    chk({tag, "_hold"}, dout, exp_q.pop_front());
    m1_n = 1'b1; iorq_n = 1'b1;
    tick(2);
  endtask

  task automatic fetch(input logic [7:0] op);
    cpu_din = op; m1_n = 1'b0;
    tick(2);
    m1_n = 1'b1;
    tick(1);
    cpu_din = 8'h00;
    tick(1);
  endtask

  task automatic reti();
    fetch(8'hED);
    fetch(8'h4D);
    tick(1);
  endtask

  task automatic pulse_trg(input logic [CHANNELS-1:0] mask, output logic [CHANNELS-1:0] seen);
    seen = '0;
    trg = trg | mask;
    repeat (4) begin tick(1); seen = seen | zc_to; end
    trg = trg & ~mask;
    repeat (4) begin tick(1); seen = seen | zc_to; end
  endtask

  task automatic wait_zc(input int ch, input int bound, output int at, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      tick(1);
      if (zc_to[ch]) seen = 1'b1;
    end
    at = ena_cnt;
  endtask

  initial begin
    int at;
    int t_ref;
    bit seen;
    logic [CHANNELS-1:0] zs;

    tick(3);
    chk("rst_dout", dout, 8'hFF);
    chk("rst_int_n", int_n, 1'b1);
    chk("rst_zc", zc_to, 4'h0);
    chk("rst_ieo_hi", ieo, 1'b1);
    iei = 1'b0; #1;
    chk("rst_ieo_lo", ieo, 1'b0);
    iei = 1'b1;
    tick(1);
    reset_n = 1'b1;
    tick(2);
    io_read("rst_cnt0", 0, 8'h00);

    // timer, auto start, prescale 16, TC 4
    io_write(0, 8'h85);
    io_write(0, 8'h04);
    t_ref = wr_cyc;
    exp_q.push_back(64);
    io_write(0, 8'hE0);
    wait_zc(0, 200, at, seen);
    chk("t1_zc_seen", seen, 1);
    chk("t1_first", at - t_ref, exp_q.pop_front());
    chk("t1_int", int_n, 1'b0);
    tick(1);
    chk("t1_zc_width", zc_to[0], 1'b0);
    intack("t1_ack", 8'hE0);
    chk("t1_int_ack", int_n, 1'b1);
    t_ref = at;
    exp_q.push_back(64);
    wait_zc(0, 200, at, seen);
    chk("t1_period", at - t_ref, exp_q.pop_front());
    chk("t1_blocked", int_n, 1'b1);
    reti();
    chk("t1_reti_int", int_n, 1'b0);
    intack("t1_ack2", 8'hE0);
    reti();
    io_write(0, 8'h03);
    chk("t1_off_int", int_n, 1'b1);
    chk("t1_off_ieo", ieo, 1'b1);

    // counter mode on ch2, including an edge lost while clock_ena is low
    io_write(2, 8'h57);
    io_write(2, 8'h03);
    io_read("t2_rd3", 2, 8'h03);
    clock_ena = 1'b0;
    trg[2] = 1'b1; tick(3);
    trg[2] = 1'b0; tick(3);
    clock_ena = 1'b1;
    tick(3);
    io_read("t2_stall", 2, 8'h03);
    pulse_trg(4'b0100, zs);
    chk("t2_nozc1", zs[2], 1'b0);
    io_read("t2_rd2", 2, 8'h02);
    pulse_trg(4'b0100, zs);
    io_read("t2_rd1", 2, 8'h01);
    pulse_trg(4'b0100, zs);
    chk("t2_zc", zs[2], 1'b1);
    io_read("t2_reload", 2, 8'h03);
    chk("t2_int", int_n, 1'b1);
    io_write(2, 8'h03);

    // priority among ch1/ch3, then ch0 preempting ch1
    io_write(1, 8'hD7); io_write(1, 8'h01);
    io_write(3, 8'hD7); io_write(3, 8'h01);
    pulse_trg(4'b1010, zs);
    chk("t3_zc13", zs, 4'b1010);
    chk("t3_int", int_n, 1'b0);
    intack("t3_ack1", 8'hE2);
    chk("t3_ch3_blk", int_n, 1'b1);
    reti();
    chk("t3_int3", int_n, 1'b0);
    intack("t3_ack3", 8'hE6);
    reti();
    chk("t3_idle", int_n, 1'b1);
    io_write(0, 8'hD7); io_write(0, 8'h01);
    pulse_trg(4'b0010, zs);
    intack("t3_ack1b", 8'hE2);
    pulse_trg(4'b0001, zs);
    chk("t3_ch0_int", int_n, 1'b0);
    intack("t3_ack0", 8'hE0);
    reti();
    reti();
    chk("t3_ieo", ieo, 1'b1);

    // daisy chain disabled upstream
    iei = 1'b0;
    tick(1);
    pulse_trg(4'b0001, zs);
    chk("t4_int", int_n, 1'b1);
    chk("t4_ieo", ieo, 1'b0);
    intack("t4_ack_none", 8'hFF);
    iei = 1'b1; #1;
    chk("t4_int_en", int_n, 1'b0);
    intack("t4_ack", 8'hE0);
    reti();
    chk("t4_ieo_end", ieo, 1'b1);

    // TC=0 means 256, software reset mid-count, restart on TC write
    io_write(1, 8'h87);
    io_write(1, 8'h00);
    t_ref = wr_cyc;
    exp_q.push_back(4096);
    wait_zc(1, 4200, at, seen);
    chk("t5_first", at - t_ref, exp_q.pop_front());
    t_ref = at;
    exp_q.push_back(4096);
    wait_zc(1, 4200, at, seen);
    chk("t5_period", at - t_ref, exp_q.pop_front());
    chk("t5_int", int_n, 1'b0);
    io_write(1, 8'h03);
    chk("t5_swrst_int", int_n, 1'b1);
    io_read("t5_swrst_cnt", 1, 8'h00);
    wait_zc(1, 4300, at, seen);
    chk("t5_stopped", seen, 1'b0);
    io_write(1, 8'h85);
    io_write(1, 8'h00);
    t_ref = wr_cyc;
    exp_q.push_back(4096);
    wait_zc(1, 4200, at, seen);
    chk("t5_restart", at - t_ref, exp_q.pop_front());
    io_write(1, 8'h03);

    // asynchronous reset during INTACK
    io_write(0, 8'h87);
    io_write(0, 8'h01);
    wait_zc(0, 40, at, seen);
    chk("t6_int", int_n, 1'b0);
    exp_q.push_back(32'hE0);
    m1_n = 1'b0; iorq_n = 1'b0;
    tick(1);
    chk("t6_ack", dout, exp_q.pop_front());
    clock_ena = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("t6_dout", dout, 8'hFF);
    chk("t6_int_n", int_n, 1'b1);
    chk("t6_zc", zc_to, 4'h0);
    chk("t6_ieo", ieo, 1'b1);
    m1_n = 1'b1; iorq_n = 1'b1;
    tick(2);
    reset_n = 1'b1;
    clock_ena = 1'b1;
    tick(2);
    io_read("t6_cnt", 0, 8'h00);
    chk("t6_int_end", int_n, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
